drum_strike_controller: RTL and testbench

- Sequences the drum mesh (compMesh) and replaces the ad-hoc key-edge logic at the top level.
- Synchronizes and debounces the three note keys and latches the eta for the selected note.
- Issues a timed strike reset to the mesh, then gates and latches mesh samples into the audio DAC path.
- Bounds each note to a fixed number of samples, then mutes.

---
 rtl/drum_strike_controller.sv | 186 ++++++++++++++++++
 tb/tb_drum_strike_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_strike_controller.sv
// Drum mesh strike sequencer: key debounce, timed strike reset,
// gated sample capture into the DAC path and per-note auto-mute.
module drum_strike_controller #(
    parameter logic [15:0] DEB_CYC      = 16'd50000,
    parameter logic [7:0]  STRIKE_CYC   = 8'd4,
    parameter logic [15:0] PLAY_SAMPLES = 16'd44100,
    parameter logic [17:0] ETA1         = 18'h0_0003,
    parameter logic [17:0] ETA2         = 18'h0_0400,
    parameter logic [17:0] ETA3         = 18'h0_0010
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  key_n,
    input  logic        mesh_valid,
    input  logic [17:0] mesh_out,
    output logic        mesh_reset,
    output logic [17:0] eta_sel,
    output logic [15:0] audio_sample,
    output logic        sample_strobe,
    output logic [1:0]  note_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        STRIKE,
        PLAY
    } state_t;

    state_t state_q;

    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       acc_q;
    logic [2:0]       acc_d;
    logic [2:0][15:0] deb_q;
    logic [2:0][15:0] deb_d;
    logic [2:0]       press;

    logic        mv_q;
    logic        rise;
    logic [7:0]  scnt_q;
    logic [15:0] pcnt_q;
    logic        mrst_q;
    logic [17:0] eta_q;
    logic [15:0] audio_q;
    logic        strobe_q;
    logic [1:0]  note_q;
    logic        busy_q;

    logic        any_press;
    logic [17:0] eta_new;
    logic [1:0]  note_new;
    logic        play_done;

    // Debounce: count cycles the synced level disagrees with the accepted one
    always_comb begin
        acc_d = acc_q;
        deb_d = deb_q;
        press = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == acc_q[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] == DEB_CYC - 16'd1) begin
                acc_d[i] = ~acc_q[i];
                deb_d[i] = '0;
                press[i] = acc_q[i];
            end else begin
                deb_d[i] = deb_q[i] + 16'd1;
            end
        end
    end

    // Key synchronizers and debounce state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            deb_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            deb_q   <= deb_d;
        end
    end

    // Note select with KEY1 > KEY2 > KEY3 priority
    always_comb begin
        any_press = |press;
        eta_new   = ETA3;
        note_new  = 2'd0;
        priority case (1'b1)
            press[0]: begin
                eta_new  = ETA1;
                note_new = 2'd1;
            end
            press[1]: begin
                eta_new  = ETA2;
                note_new = 2'd2;
            end
            press[2]: begin
                eta_new  = ETA3;
                note_new = 2'd3;
            end
            default: begin
                eta_new  = ETA3;
                note_new = 2'd0;
            end
        endcase
    end

    assign rise      = mesh_valid & ~mv_q;
    assign play_done = (pcnt_q == PLAY_SAMPLES);

    // Strike/play sequencer with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mv_q     <= 1'b0;
            scnt_q   <= '0;
            pcnt_q   <= '0;
            mrst_q   <= 1'b0;
            eta_q    <= ETA3;
            audio_q  <= '0;
            strobe_q <= 1'b0;
            note_q   <= 2'd0;
            busy_q   <= 1'b0;
        end else begin
            mv_q     <= mesh_valid;
            strobe_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_press) begin
                        state_q <= STRIKE;
                        eta_q   <= eta_new;
                        note_q  <= note_new;
                        scnt_q  <= '0;
                        mrst_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                STRIKE: begin
                    if (scnt_q == STRIKE_CYC - 8'd1) begin
                        state_q <= PLAY;
                        mrst_q  <= 1'b0;
                        pcnt_q  <= '0;
                    end else begin
                        scnt_q <= scnt_q + 8'd1;
                    end
                end
                PLAY: begin
                    if (rise && !play_done) begin
                        audio_q  <= mesh_out[17:2];
                        strobe_q <= 1'b1;
                        pcnt_q   <= pcnt_q + 16'd1;
                    end
                    if (any_press) begin
                        state_q <= STRIKE;
                        eta_q   <= eta_new;
                        note_q  <= note_new;
                        scnt_q  <= '0;
                        mrst_q  <= 1'b1;
                    end else if (play_done) begin
                        state_q <= IDLE;
                        audio_q <= '0;
                        note_q  <= 2'd0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mesh_reset    = mrst_q;
    assign eta_sel       = eta_q;
    assign audio_sample  = audio_q;
    assign sample_strobe = strobe_q;
    assign note_id       = note_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_drum_strike_controller.sv
// Bench for drum_strike_controller: scenario tasks plus a sample
// scoreboard that checks every strobe against queued expectations.
module tb_drum_strike_controller;

    logic        clk;
    logic        reset_n;
    logic [2:0]  key_n;
    logic        mesh_valid;
    logic [17:0] mesh_out;
    logic        mesh_reset;
    logic [17:0] eta_sel;
    logic [15:0] audio_sample;
    logic        sample_strobe;
    logic [1:0]  note_id;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int n_strobe = 0;
    logic [15:0] exp_q[$];
    bit prev_strobe = 0;

    drum_strike_controller #(
        .DEB_CYC     (16'd4),
        .STRIKE_CYC  (8'd3),
        .PLAY_SAMPLES(16'd5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_n        (key_n),
        .mesh_valid   (mesh_valid),
        .mesh_out     (mesh_out),
        .mesh_reset   (mesh_reset),
        .eta_sel      (eta_sel),
        .audio_sample (audio_sample),
        .sample_strobe(sample_strobe),
        .note_id      (note_id),
        .busy         (busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_of(input logic [17:0] v);
        logic signed [17:0] s;
        s = $signed(v) >>> 2;
        return s[15:0];
    endfunction

    // Scoreboard: every strobe must match the oldest queued sample
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_strobe = 0;
        end else begin
            if (sample_strobe) begin
                logic [15:0] e;
                n_strobe++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL strobe_unexpected: audio %h, required no strobe",
                             audio_sample);
                end else begin
                    e = exp_q.pop_front();
                    if (audio_sample !== e) begin
                        n_bad++;
                        $display("FAIL sample_value: got %h, required %h",
                                 audio_sample, e);
                    end
                end
                if (prev_strobe) begin
                    n_bad++;
                    $display("FAIL strobe_width: got 2+ cycles, required 1");
                end
            end
            prev_strobe = sample_strobe;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold keys low 10 cycles, then release; observe the strike window
    task automatic do_press(input logic [2:0] kn, input bit pulse,
                            output int hi, output logic [17:0] eta,
                            output logic [1:0] note);
        hi = 0;
        eta = 'x;
        note = 'x;
        key_n = kn;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) key_n = 3'b111;
            if (mesh_reset) begin
                if (hi == 0) begin
                    eta = eta_sel;
                    note = note_id;
                end
                hi++;
            end
            mesh_valid = (pulse && mesh_reset) ? ~mesh_valid : 1'b0;
        end
        mesh_valid = 0;
    endtask

    task automatic pulse_valid(input logic [17:0] v, input int hold,
                               input bit expect_it);
        mesh_out = v;
        mesh_valid = 1;
        if (expect_it) exp_q.push_back(exp_of(v));
        tick(hold);
        mesh_valid = 0;
        tick(1);
    endtask

    task automatic test_reset;
        reset_n = 0;
        key_n = 3'b111;
        mesh_valid = 0;
        mesh_out = '0;
        tick(3);
        n_vec += 6;
        if (mesh_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mesh_reset: got %b, required 0", mesh_reset);
        end
        if (eta_sel !== 18'h0_0010) begin
            n_bad++;
            $display("FAIL rst_eta: got %h, required 00010", eta_sel);
        end
        if (audio_sample !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_audio: got %h, required 0", audio_sample);
        end
        if (sample_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_strobe: got %b, required 0", sample_strobe);
        end
        if (note_id !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_note: got %0d, required 0", note_id);
        end
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got %b, required 0", busy);
        end
        reset_n = 1;
        tick(12);
    endtask

    task automatic test_glitch;
        bit seen = 0;
        key_n = 3'b101;
        tick(3);
        key_n = 3'b111;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy || mesh_reset) seen = 1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_reject: got busy/strike 1, required 0");
        end
    endtask

    task automatic test_single_note;
        int hi;
        logic [17:0] eta;
        logic [1:0] note;
        do_press(3'b101, 0, hi, eta, note);
        n_vec += 5;
        if (hi !== 3) begin
            n_bad++;
            $display("FAIL single_strike_len: got %0d, required 3", hi);
        end
        if (eta !== 18'h0_0400) begin
            n_bad++;
            $display("FAIL single_eta: got %h, required 00400", eta);
        end
        if (note !== 2'd2) begin
            n_bad++;
            $display("FAIL single_note: got %0d, required 2", note);
        end
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_busy: got %b, required 1", busy);
        end
        if (eta_sel !== 18'h0_0400) begin
            n_bad++;
            $display("FAIL single_eta_hold: got %h, required 00400", eta_sel);
        end
    endtask

    task automatic test_playback;
        int s0 = n_strobe;
        for (int i = 0; i < 5; i++) begin
            pulse_valid(18'h1_0004, (i == 2) ? 6 : 1, 1);
            tick(1);
            if (i == 3) begin
                n_vec++;
                if (busy !== 1'b1 || note_id !== 2'd2) begin
                    n_bad++;
                    $display("FAIL play_mid: got busy %b note %0d, required 1 2",
                             busy, note_id);
                end
            end
        end
        n_vec += 4;
        if (n_strobe - s0 !== 5) begin
            n_bad++;
            $display("FAIL play_strobes: got %0d, required 5", n_strobe - s0);
        end
        if (note_id !== 2'd0) begin
            n_bad++;
            $display("FAIL play_end_note: got %0d, required 0", note_id);
        end
        if (audio_sample !== 16'h0) begin
            n_bad++;
            $display("FAIL play_end_audio: got %h, required 0", audio_sample);
        end
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL play_end_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_simultaneous;
        int hi;
        logic [17:0] eta;
        logic [1:0] note;
        logic [17:0] v[5];
        v = '{18'h3_FFFC, 18'h2_0001, 18'h1_FFFF, 18'h0_0007, 18'h0_0000};
        do_press(3'b000, 1, hi, eta, note);
        n_vec += 3;
        if (note !== 2'd1) begin
            n_bad++;
            $display("FAIL simul_note: got %0d, required 1", note);
        end
        if (eta !== 18'h0_0003) begin
            n_bad++;
            $display("FAIL simul_eta: got %h, required 00003", eta);
        end
        if (hi !== 3) begin
            n_bad++;
            $display("FAIL simul_strike_len: got %0d, required 3", hi);
        end
        for (int i = 0; i < 5; i++) pulse_valid(v[i], 1, 1);
        tick(1);
        n_vec += 2;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_end_busy: got %b, required 0", busy);
        end
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL simul_pending: got %0d queued, required 0",
                     exp_q.size());
        end
    endtask

    task automatic test_retrigger;
        int hi;
        logic [17:0] eta;
        logic [1:0] note;
        bit seen = 0;
        do_press(3'b101, 0, hi, eta, note);
        pulse_valid(18'h0_1000, 1, 1);
        pulse_valid(18'h3_0000, 1, 1);
        do_press(3'b011, 0, hi, eta, note);
        n_vec += 3;
        if (hi !== 3) begin
            n_bad++;
            $display("FAIL retrig_strike_len: got %0d, required 3", hi);
        end
        if (eta !== 18'h0_0010) begin
            n_bad++;
            $display("FAIL retrig_eta: got %h, required 00010", eta);
        end
        if (note !== 2'd3) begin
            n_bad++;
            $display("FAIL retrig_note: got %0d, required 3", note);
        end
        for (int i = 0; i < 4; i++) pulse_valid(18'h0_0100 + 18'(i), 1, 1);
        tick(1);
        n_vec++;
        if (busy !== 1'b1 || note_id !== 2'd3) begin
            n_bad++;
            $display("FAIL retrig_count: got busy %b note %0d, required 1 3",
                     busy, note_id);
        end
        pulse_valid(18'h2_8000, 1, 1);
        tick(1);
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL retrig_end_busy: got %b, required 0", busy);
        end
        do_press(3'b110, 0, hi, eta, note);
        pulse_valid(18'h0_0404, 1, 1);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        n_vec += 6;
        if (mesh_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL async_mesh_reset: got %b, required 0", mesh_reset);
        end
        if (eta_sel !== 18'h0_0010) begin
            n_bad++;
            $display("FAIL async_eta: got %h, required 00010", eta_sel);
        end
        if (audio_sample !== 16'h0) begin
            n_bad++;
            $display("FAIL async_audio: got %h, required 0", audio_sample);
        end
        if (sample_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL async_strobe: got %b, required 0", sample_strobe);
        end
        if (note_id !== 2'd0) begin
            n_bad++;
            $display("FAIL async_note: got %0d, required 0", note_id);
        end
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_busy: got %b, required 0", busy);
        end
        tick(2);
        reset_n = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy || mesh_reset) seen = 1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL async_no_pending: got strike after reset, required none");
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_note();
        test_playback();
        test_simultaneous();
        test_retrigger();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
